// File: rtl/star_cam_lut_responder.sv
// Responder side of the STAR CAM/SUB and LUT interfaces: holds the CAM value table and
// the exp LUT, loads them serially, and answers match/subtract/exp/sum requests combinationally.
module star_cam_lut_responder #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned DW      = 8,
  parameter int unsigned AW      = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_start,
  input  logic               cfg_we,
  input  logic [DW-1:0]      cfg_wdata,
  output logic               ready,
  input  logic               CAMSUB_req,
  input  logic [DW-1:0]      xi,
  output logic [ENTRIES-1:0] i_xi_MV,
  input  logic               FindSub_req,
  input  logic [ENTRIES-1:0] o_xmax_MV,
  input  logic [ENTRIES-1:0] o_xi_MV,
  output logic [ENTRIES-1:0] i_sub_MV,
  input  logic [ENTRIES-1:0] o_sub_MV,
  input  logic [ENTRIES-1:0] o_sum_MV,
  output logic [DW-1:0]      exp,
  output logic [DW-1:0]      Sum_exp,
  output logic [7:0]         miss_cnt,
  output logic               err
);

  localparam int unsigned SW = DW + AW;  // accumulator wide enough for ENTRIES full-scale terms

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_CAM = 2'd1,
    LOAD_LUT = 2'd2,
    READY    = 2'd3
  } state_t;

  state_t            state_q;
  logic [AW-1:0]     ptr_q;
  logic              ready_q;
  logic [7:0]        miss_q;
  logic              err_q;
  logic [DW-1:0]     cam_q [ENTRIES];
  logic [DW-1:0]     lut_q [ENTRIES];

  logic [ENTRIES-1:0] xi_match;
  logic [ENTRIES-1:0] sub_match;
  logic [DW-1:0]      diff;
  logic [SW-1:0]      acc;
  logic [DW-1:0]      sum_sat;
  logic               cam_miss;
  logic               sub_miss;
  logic [8:0]         miss_sum;
  logic [7:0]         miss_d;
  logic               req_err;
  logic               we_err;

  // Index of the highest set bit; an empty vector maps to entry 0.
  function automatic logic [AW-1:0] hi_idx(input logic [ENTRIES-1:0] v);
    hi_idx = '0;
    for (int k = 0; k < int'(ENTRIES); k++) begin
      if (v[k]) hi_idx = AW'(k);
    end
  endfunction

  // CAM searches for the key and for the subtraction result.
  always_comb begin
    xi_match  = '0;
    sub_match = '0;
    diff      = cam_q[hi_idx(o_xmax_MV)] - cam_q[hi_idx(o_xi_MV)];
    for (int k = 0; k < int'(ENTRIES); k++) begin
      xi_match[k]  = (cam_q[k] == xi);
      sub_match[k] = (cam_q[k] == diff);
    end
  end

  // Saturating LUT sum over the selected entries.
  always_comb begin
    acc = '0;
    for (int k = 0; k < int'(ENTRIES); k++) begin
      if (o_sum_MV[k]) acc = acc + SW'(lut_q[k]);
    end
    sum_sat = (acc[SW-1:DW] != '0) ? {DW{1'b1}} : acc[DW-1:0];
  end

  // Miss statistics and error sources, evaluated for the coming edge.
  always_comb begin
    cam_miss = CAMSUB_req && ready_q && (xi_match == '0);
    sub_miss = FindSub_req && ready_q && (sub_match == '0);
    miss_sum = 9'(miss_q) + 9'(cam_miss) + 9'(sub_miss);
    miss_d   = miss_sum[8] ? 8'hFF : miss_sum[7:0];
    req_err  = (CAMSUB_req || FindSub_req) && !ready_q;
    we_err   = cfg_we && ((state_q == IDLE) || (state_q == READY));
  end

  assign i_xi_MV  = (CAMSUB_req && ready_q) ? xi_match : '0;
  assign i_sub_MV = (FindSub_req && ready_q) ? sub_match : '0;
  assign exp      = ready_q ? lut_q[hi_idx(o_sub_MV)] : '0;
  assign Sum_exp  = ready_q ? sum_sat : '0;
  assign ready    = ready_q;
  assign miss_cnt = miss_q;
  assign err      = err_q;

  // Load FSM, tables and statistics; cfg_start restarts from a clean slate in any state.
  always_ff @(posedge clk) begin
    if (!reset_n || cfg_start) begin
      state_q <= reset_n ? LOAD_CAM : IDLE;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      miss_q  <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < int'(ENTRIES); k++) begin
        cam_q[k] <= '0;
        lut_q[k] <= '0;
      end
    end else begin
      miss_q <= miss_d;
      if (req_err || we_err) err_q <= 1'b1;
      case (state_q)
        LOAD_CAM: begin
          if (cfg_we) begin
            cam_q[ptr_q] <= cfg_wdata;
            ptr_q        <= ptr_q + AW'(1);
            if (ptr_q == AW'(ENTRIES - 1)) state_q <= LOAD_LUT;
          end
        end
        LOAD_LUT: begin
          if (cfg_we) begin
            lut_q[ptr_q] <= cfg_wdata;
            ptr_q        <= ptr_q + AW'(1);
            if (ptr_q == AW'(ENTRIES - 1)) begin
              state_q <= READY;
              ready_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_star_cam_lut_responder.sv
// Directed bench for star_cam_lut_responder: table-driven response vectors plus
// hand-written load, error, reset-mid-load, duplicate and saturation sequences.
module tb_star_cam_lut_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_start, cfg_we;
  logic [7:0]  cfg_wdata;
  logic        ready;
  logic        CAMSUB_req, FindSub_req;
  logic [7:0]  xi;
  logic [63:0] i_xi_MV, o_xmax_MV, o_xi_MV, i_sub_MV, o_sub_MV, o_sum_MV;
  logic [7:0]  exp_o, Sum_exp, miss_cnt;
  logic        err;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] cam_img [64];
  logic [7:0] lut_img [64];

  typedef struct {
    logic        camsub;
    logic [7:0]  xi;
    logic        findsub;
    logic [63:0] xmax;
    logic [63:0] xim;
    logic [63:0] sub;
    logic [63:0] sum;
    logic [63:0] e_xi;
    logic [63:0] e_sub;
    logic [7:0]  e_exp;
    logic [7:0]  e_sum;
    logic [7:0]  e_miss;
  } vec_t;

  vec_t vt [8];

  always #5 clk = ~clk;

  star_cam_lut_responder dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_we(cfg_we),
    .cfg_wdata(cfg_wdata), .ready(ready), .CAMSUB_req(CAMSUB_req), .xi(xi),
    .i_xi_MV(i_xi_MV), .FindSub_req(FindSub_req), .o_xmax_MV(o_xmax_MV),
    .o_xi_MV(o_xi_MV), .i_sub_MV(i_sub_MV), .o_sub_MV(o_sub_MV),
    .o_sum_MV(o_sum_MV), .exp(exp_o), .Sum_exp(Sum_exp), .miss_cnt(miss_cnt), .err(err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_start = 0; cfg_we = 0; cfg_wdata = 0; CAMSUB_req = 0; FindSub_req = 0;
    xi = 0; o_xmax_MV = 0; o_xi_MV = 0; o_sub_MV = 0; o_sum_MV = 0;
  endtask

  task automatic load_tables();
    cfg_start = 1;
    tick();
    cfg_start = 0;
    for (int i = 0; i < 128; i++) begin
      cfg_we    = 1;
      cfg_wdata = (i < 64) ? cam_img[i] : lut_img[i-64];
      if (i == 127) chk("ready_before_last_we", 64'(ready), 64'd0);
      tick();
    end
    cfg_we = 0;
    chk("ready_after_load", 64'(ready), 64'd1);
    chk("err_after_load", 64'(err), 64'd0);
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    tick(); tick();
    reset_n = 1;

    // Reset state and gating of exp/Sum_exp before any load
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_miss", 64'(miss_cnt), 64'd0);
    o_sub_MV = 64'd1 << 9; o_sum_MV = '1;
    #1;
    chk("rst_exp_gated", 64'(exp_o), 64'd0);
    chk("rst_sum_gated", 64'(Sum_exp), 64'd0);
    idle_inputs();

    for (int k = 0; k < 64; k++) begin
      cam_img[k] = 8'(k);
      lut_img[k] = 8'(k + 1);
    end
    load_tables();

    // {camsub, xi, findsub, xmax, xi_mv, sub_mv, sum_mv, e_xi, e_sub, e_exp, e_sum, e_miss}
    vt[0] = '{1, 8'd5,   0, 64'd0, 64'd0, 64'd1 << 9, 64'h7, 64'h20, 64'd0, 8'd10, 8'd6, 8'd0};
    vt[1] = '{1, 8'd200, 0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 8'd1, 8'd0, 8'd1};
    vt[2] = '{0, 8'd5,   1, 64'd1 << 40, 64'd1 << 15, 64'd1 << 63, 64'hF000_0000_0000_0000,
              64'd0, 64'd1 << 25, 8'd64, 8'd250, 8'd1};
    vt[3] = '{0, 8'd0,   1, (64'd1 << 40) | 64'h8, 64'd1 << 15, (64'd1 << 9) | 64'h4,
              64'hFF00_0000_0000_0000, 64'd0, 64'd1 << 25, 8'd10, 8'd255, 8'd1};
    vt[4] = '{1, 8'd63,  1, 64'd0, 64'd1 << 15, 64'd0, 64'd0, 64'h8000_0000_0000_0000,
              64'd0, 8'd1, 8'd0, 8'd2};
    vt[5] = '{1, 8'd64,  1, 64'd0, 64'd1 << 15, 64'd0, 64'd0, 64'd0, 64'd0, 8'd1, 8'd0, 8'd4};
    vt[6] = '{0, 8'd0,   0, 64'd0, 64'd0, '1, '1, 64'd0, 64'd0, 8'd64, 8'd255, 8'd4};
    vt[7] = '{1, 8'd0,   1, 64'd1 << 10, 64'd1 << 10, 64'd0, 64'd0, 64'd1, 64'd1, 8'd1, 8'd0, 8'd4};

    for (int v = 0; v < 8; v++) begin
      CAMSUB_req = vt[v].camsub; xi = vt[v].xi; FindSub_req = vt[v].findsub;
      o_xmax_MV = vt[v].xmax; o_xi_MV = vt[v].xim; o_sub_MV = vt[v].sub; o_sum_MV = vt[v].sum;
      #1;
      chk($sformatf("v%0d_i_xi_MV", v), i_xi_MV, vt[v].e_xi);
      chk($sformatf("v%0d_i_sub_MV", v), i_sub_MV, vt[v].e_sub);
      chk($sformatf("v%0d_exp", v), 64'(exp_o), 64'(vt[v].e_exp));
      chk($sformatf("v%0d_Sum_exp", v), 64'(Sum_exp), 64'(vt[v].e_sum));
      tick();
      chk($sformatf("v%0d_miss_cnt", v), 64'(miss_cnt), 64'(vt[v].e_miss));
      chk($sformatf("v%0d_err", v), 64'(err), 64'd0);
    end
    idle_inputs();

    // Illegal cfg_we in READY: sticky err, tables untouched
    cfg_we = 1; cfg_wdata = 8'hAA;
    tick();
    cfg_we = 0;
    chk("ready_we_err", 64'(err), 64'd1);
    CAMSUB_req = 1; xi = 8'd5;
    #1;
    chk("ready_we_table_kept", i_xi_MV, 64'h20);
    tick();
    chk("err_sticky", 64'(err), 64'd1);
    idle_inputs();

    // cfg_start clears err/miss; request during load is gated and flags err
    cfg_start = 1;
    tick();
    cfg_start = 0;
    chk("start_err_clr", 64'(err), 64'd0);
    chk("start_miss_clr", 64'(miss_cnt), 64'd0);
    chk("start_ready_clr", 64'(ready), 64'd0);
    CAMSUB_req = 1; xi = 8'd5; o_sub_MV = 64'd1 << 9;
    #1;
    chk("load_req_gated", i_xi_MV, 64'd0);
    chk("load_exp_gated", 64'(exp_o), 64'd0);
    tick();
    chk("load_req_err", 64'(err), 64'd1);
    idle_inputs();

    // Reset in the middle of LOAD_CAM (ptr=30) returns to IDLE
    for (int i = 0; i < 30; i++) begin
      cfg_we = 1; cfg_wdata = 8'(i);
      tick();
    end
    cfg_we = 0;
    reset_n = 0;
    tick();
    reset_n = 1;
    chk("midload_rst_ready", 64'(ready), 64'd0);
    chk("midload_rst_err", 64'(err), 64'd0);
    cfg_we = 1;
    tick();
    cfg_we = 0;
    chk("midload_rst_idle_we_err", 64'(err), 64'd1);

    // Duplicate CAM values
    for (int k = 0; k < 64; k++) cam_img[k] = 8'(k);
    cam_img[3] = 8'd9; cam_img[7] = 8'd9; cam_img[9] = 8'd200;
    load_tables();
    CAMSUB_req = 1; xi = 8'd9;
    #1;
    chk("dup_match", i_xi_MV, 64'h88);
    xi = 8'd200;
    #1;
    chk("moved_match", i_xi_MV, 64'h200);
    CAMSUB_req = 0; FindSub_req = 1; o_xmax_MV = 64'd1 << 20; o_xi_MV = 64'd1 << 11;
    #1;
    chk("dup_sub_match", i_sub_MV, 64'h88);
    tick();
    chk("dup_no_miss", 64'(miss_cnt), 64'd0);
    idle_inputs();

    // Miss counter saturation: 253 singles, then double misses, 300 miss cycles in total
    CAMSUB_req = 1; xi = 8'd250;
    for (int i = 0; i < 253; i++) tick();
    chk("miss_253", 64'(miss_cnt), 64'd253);
    FindSub_req = 1; o_xmax_MV = 64'd0; o_xi_MV = 64'd2;
    #1;
    chk("dbl_miss_sub_zero", i_sub_MV, 64'd0);
    tick();
    chk("miss_dbl_to_255", 64'(miss_cnt), 64'd255);
    tick();
    chk("miss_dbl_sat", 64'(miss_cnt), 64'd255);
    FindSub_req = 0;
    for (int i = 0; i < 45; i++) tick();
    chk("miss_hold_255", 64'(miss_cnt), 64'd255);
    chk("final_err", 64'(err), 64'd0);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
